// File: rtl/f56_bus_resp.sv
// -----------------------------------------------------------------------------
// f56_bus_resp
//
// Register-file responder on the FALC56 multiplexed address/data bus.
// The host drives an address while ALE is high. It then issues either a
// write strobe (WRn low, with data on the bus) or a read strobe (RDn low,
// with the responder driving the bus). This block qualifies the access with
// one chip-select bit.
//
// Register map
//   0x00        read-only ID (ID_VALUE); writes are ignored
//   0x01-0x3F   8-bit read/write storage
//   0x40-0xFF   read as 8'h00; writes are ignored
//
// Optional build macro F56_RESP_IRQ_EN (doorbell interrupt)
//   - A committed nonzero write to 0x3F raises IRQ_O one cycle later and
//     loads 8'h01 into register 0x01.
//   - A completed read of 0x01 clears both IRQ_O and register 0x01.
//   - If a set and a clear land in the same cycle, the set wins.
//   - When the macro is undefined, IRQ_O is tied low and 0x01/0x3F are
//     ordinary storage.
//
// Parameters
//   CS_INDEX   which F56_CSn_I bit selects this responder
//   ID_VALUE   content returned for register 0x00
//   TMO_MAX    cycles allowed in ADDR_VALID without a strobe (max 63)
//
// Ports
//   FALC56_DCM_CLK0_I  in   clock; all logic on the rising edge
//   PHY_RSTn_I         in   synchronous active-low reset
//   F56_BADD_I[7:0]    in   address/data bus as seen by the responder
//   F56_BADD_O[7:0]    out  read data driven onto the bus
//   F56_BADD_OE_O      out  1 = responder drives the bus
//   F56_ALE_I          in   address latch enable, active-high
//   F56_RDn_I          in   read strobe, active-low
//   F56_WRn_I          in   write strobe, active-low
//   F56_CSn_I[1:0]     in   chip selects, active-low
//   WR_STB_O           out  one-cycle pulse per committed write
//   WR_ADD_O[7:0]      out  address of the last committed write
//   WR_DATA_O[7:0]     out  data of the last committed write
//   PROT_ERR_O         out  one-cycle pulse on a protocol violation
//   IRQ_O              out  doorbell interrupt, active-high
// -----------------------------------------------------------------------------
module f56_bus_resp #(
  parameter int         CS_INDEX = 0,
  parameter logic [7:0] ID_VALUE = 8'h56,
  parameter int         TMO_MAX  = 63
) (
  input  logic       FALC56_DCM_CLK0_I,
  input  logic       PHY_RSTn_I,
  input  logic [7:0] F56_BADD_I,
  output logic [7:0] F56_BADD_O,
  output logic       F56_BADD_OE_O,
  input  logic       F56_ALE_I,
  input  logic       F56_RDn_I,
  input  logic       F56_WRn_I,
  input  logic [1:0] F56_CSn_I,
  output logic       WR_STB_O,
  output logic [7:0] WR_ADD_O,
  output logic [7:0] WR_DATA_O,
  output logic       PROT_ERR_O,
  output logic       IRQ_O
);

  localparam logic [5:0] TMO_LIM = TMO_MAX[5:0];

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_VALID,
    S_WRITE,
    S_READ
  } state_t;

  // Stage p1: bus pins registered once
  logic [7:0] badd_p1_q;
  logic       ale_p1_q;
  logic       rdn_p1_q;
  logic       wrn_p1_q;
  logic [1:0] csn_p1_q;

  // Stage p2: previous copy of the control lines, used for edge detection
  logic       ale_p2_q;
  logic       rdn_p2_q;
  logic       wrn_p2_q;
  logic       cs_sel_n_p2_q;

  state_t     state_q;
  logic [7:0] addr_q;
  logic [7:0] wdata_q;
  logic [5:0] tmo_q;
  logic [5:0] tmo_d;
  logic [7:0] mem_q [64];
  logic [7:0] rd_data_d;

  logic [7:0] badd_o_q;
  logic       oe_q;
  logic       wr_stb_q;
  logic [7:0] wr_add_q;
  logic [7:0] wr_data_q;
  logic       prot_err_q;

  logic       cs_sel_n_p1;
  logic       cs_sel;
  logic       ale_fall;
  logic       rdn_rise;
  logic       wrn_rise;
  logic       cs_rise;
  logic       unused_csn;

`ifdef F56_RESP_IRQ_EN
  logic       irq_q;
  logic       irq_set_q;
`endif

  // Address 0x00 is the read-only ID and 0x40 and above are unbacked,
  // so only 0x01-0x3F accept writes.
  function automatic logic is_writable(input logic [7:0] a);
    return (a[7:6] == 2'b00) && (a[5:0] != 6'd0);
  endfunction

  always_ff @(posedge FALC56_DCM_CLK0_I) begin
    badd_p1_q <= F56_BADD_I;
  end

  always_ff @(posedge FALC56_DCM_CLK0_I) begin
    if (!PHY_RSTn_I) begin
      ale_p1_q      <= 1'b0;
      rdn_p1_q      <= 1'b1;
      wrn_p1_q      <= 1'b1;
      csn_p1_q      <= 2'b11;
      ale_p2_q      <= 1'b0;
      rdn_p2_q      <= 1'b1;
      wrn_p2_q      <= 1'b1;
      cs_sel_n_p2_q <= 1'b1;
    end else begin
      ale_p1_q      <= F56_ALE_I;
      rdn_p1_q      <= F56_RDn_I;
      wrn_p1_q      <= F56_WRn_I;
      csn_p1_q      <= F56_CSn_I;
      ale_p2_q      <= ale_p1_q;
      rdn_p2_q      <= rdn_p1_q;
      wrn_p2_q      <= wrn_p1_q;
      cs_sel_n_p2_q <= cs_sel_n_p1;
    end
  end

  // The chip select not owned by this instance only passes through stage p1.
  assign unused_csn  = ^csn_p1_q;
  assign cs_sel_n_p1 = csn_p1_q[CS_INDEX];
  assign cs_sel      = ~cs_sel_n_p1;
  assign ale_fall    = ale_p2_q & ~ale_p1_q;
  assign rdn_rise    = ~rdn_p2_q & rdn_p1_q;
  assign wrn_rise    = ~wrn_p2_q & wrn_p1_q;
  assign cs_rise     = ~cs_sel_n_p2_q & cs_sel_n_p1;
  assign tmo_d       = tmo_q + 6'd1;

  always_comb begin
    rd_data_d = 8'h00;
    if (addr_q == 8'h00) begin
      rd_data_d = ID_VALUE;
    end else if (addr_q[7:6] == 2'b00) begin
      rd_data_d = mem_q[addr_q[5:0]];
    end
  end

  // Stage FSM: decisions on p1/p2, outputs registered
  always_ff @(posedge FALC56_DCM_CLK0_I) begin
    if (!PHY_RSTn_I) begin
      state_q    <= S_IDLE;
      addr_q     <= 8'h00;
      wdata_q    <= 8'h00;
      tmo_q      <= 6'd0;
      badd_o_q   <= 8'h00;
      oe_q       <= 1'b0;
      wr_stb_q   <= 1'b0;
      wr_add_q   <= 8'h00;
      wr_data_q  <= 8'h00;
      prot_err_q <= 1'b0;
      for (int i = 0; i < 64; i++) begin
        mem_q[i] <= 8'h00;
      end
`ifdef F56_RESP_IRQ_EN
      irq_q      <= 1'b0;
      irq_set_q  <= 1'b0;
`endif
    end else begin
      wr_stb_q   <= 1'b0;
      prot_err_q <= 1'b0;
`ifdef F56_RESP_IRQ_EN
      irq_set_q  <= 1'b0;
      if (irq_set_q) begin
        irq_q    <= 1'b1;
        mem_q[1] <= 8'h01;
      end
`endif
      case (state_q)
        S_IDLE: begin
          if (ale_p1_q) begin
            state_q <= S_ADDR;
            addr_q  <= badd_p1_q;
          end
        end

        S_ADDR: begin
          if (ale_p1_q) begin
            addr_q <= badd_p1_q;
          end else if (ale_fall) begin
            state_q <= S_ADDR_VALID;
            tmo_q   <= 6'd0;
          end
        end

        S_ADDR_VALID: begin
          if (!wrn_p1_q && !rdn_p1_q) begin
            prot_err_q <= 1'b1;
            state_q    <= S_IDLE;
          end else if (ale_p1_q) begin
            state_q <= S_ADDR;
            addr_q  <= badd_p1_q;
          end else if (cs_sel && !wrn_p1_q) begin
            state_q <= S_WRITE;
            wdata_q <= badd_p1_q;
          end else if (cs_sel && !rdn_p1_q) begin
            state_q  <= S_READ;
            oe_q     <= 1'b1;
            badd_o_q <= rd_data_d;
          end else if (tmo_d == TMO_LIM) begin
            state_q <= S_IDLE;
          end else begin
            tmo_q <= tmo_d;
          end
        end

        S_WRITE: begin
          if (ale_p1_q) begin
            prot_err_q <= 1'b1;
            state_q    <= S_ADDR;
            addr_q     <= badd_p1_q;
          end else if (cs_rise) begin
            prot_err_q <= 1'b1;
            state_q    <= S_IDLE;
          end else if (wrn_rise) begin
            // Commit the last sample taken while the strobe was low.
            state_q <= S_IDLE;
            if (is_writable(addr_q)) begin
              mem_q[addr_q[5:0]] <= wdata_q;
              wr_stb_q           <= 1'b1;
              wr_add_q           <= addr_q;
              wr_data_q          <= wdata_q;
`ifdef F56_RESP_IRQ_EN
              if ((addr_q == 8'h3F) && (wdata_q != 8'h00)) begin
                irq_set_q <= 1'b1;
              end
`endif
            end
          end else if (!wrn_p1_q) begin
            wdata_q <= badd_p1_q;
          end
        end

        S_READ: begin
          if (ale_p1_q) begin
            prot_err_q <= 1'b1;
            oe_q       <= 1'b0;
            badd_o_q   <= 8'h00;
            state_q    <= S_ADDR;
            addr_q     <= badd_p1_q;
          end else if (cs_rise) begin
            prot_err_q <= 1'b1;
            oe_q       <= 1'b0;
            badd_o_q   <= 8'h00;
            state_q    <= S_IDLE;
          end else if (rdn_rise) begin
            oe_q     <= 1'b0;
            badd_o_q <= 8'h00;
            state_q  <= S_IDLE;
`ifdef F56_RESP_IRQ_EN
            // A pending set outranks the acknowledge.
            if ((addr_q == 8'h01) && !irq_set_q) begin
              irq_q    <= 1'b0;
              mem_q[1] <= 8'h00;
            end
`endif
          end else begin
            badd_o_q <= rd_data_d;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign F56_BADD_O    = badd_o_q;
  assign F56_BADD_OE_O = oe_q;
  assign WR_STB_O      = wr_stb_q;
  assign WR_ADD_O      = wr_add_q;
  assign WR_DATA_O     = wr_data_q;
  assign PROT_ERR_O    = prot_err_q;
`ifdef F56_RESP_IRQ_EN
  assign IRQ_O         = irq_q;
`else
  assign IRQ_O         = 1'b0;
`endif

endmodule

// File: tb/tb_f56_bus_resp.sv
module tb_f56_bus_resp;

  logic       clk;
  logic       rstn;
  logic [7:0] badd_i;
  logic [7:0] badd_o;
  logic       oe;
  logic       ale;
  logic       rdn;
  logic       wrn;
  logic [1:0] csn;
  logic       wr_stb;
  logic [7:0] wr_add;
  logic [7:0] wr_data;
  logic       prot_err;
  logic       irq;

  int checks = 0;
  int errors = 0;

  int         stb_cnt  = 0;
  int         prot_cnt = 0;
  int         oe_cnt   = 0;
  logic [7:0] oe_data  = 8'h00;

  f56_bus_resp dut (
    .FALC56_DCM_CLK0_I (clk),
    .PHY_RSTn_I        (rstn),
    .F56_BADD_I        (badd_i),
    .F56_BADD_O        (badd_o),
    .F56_BADD_OE_O     (oe),
    .F56_ALE_I         (ale),
    .F56_RDn_I         (rdn),
    .F56_WRn_I         (wrn),
    .F56_CSn_I         (csn),
    .WR_STB_O          (wr_stb),
    .WR_ADD_O          (wr_add),
    .WR_DATA_O         (wr_data),
    .PROT_ERR_O        (prot_err),
    .IRQ_O             (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Event counters, sampled away from the active edge.
  always @(negedge clk) begin
    if (wr_stb) stb_cnt++;
    if (prot_err) prot_cnt++;
    if (oe) begin
      oe_cnt++;
      oe_data = badd_o;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    ale    = 1'b0;
    rdn    = 1'b1;
    wrn    = 1'b1;
    csn    = 2'b11;
    badd_i = 8'h00;
  endtask

  // Address phase: ALE high for two cycles with CSn[0] asserted.
  task automatic bus_addr(input logic [7:0] a);
    tick();
    csn    = 2'b10;
    ale    = 1'b1;
    badd_i = a;
    tick();
    tick();
    ale = 1'b0;
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d,
                          input int gap, input bit abort);
    bus_addr(a);
    badd_i = d;
    repeat (gap + 1) tick();
    wrn = 1'b0;
    if (abort) begin
      tick();
      tick();
      csn = 2'b11;
      repeat (3) tick();
    end else begin
      repeat (5) tick();
    end
    wrn = 1'b1;
    repeat (3) tick();
    csn = 2'b11;
    tick();
    tick();
  endtask

  // RDn low for five cycles; returns the last value seen while OE was high,
  // the number of OE-high cycles, and OE one cycle after RDn fell.
  task automatic do_read(input logic [7:0] a, output logic [7:0] data,
                         output int oe_cycles, output logic oe_early);
    int oe0;
    oe0 = oe_cnt;
    bus_addr(a);
    badd_i = 8'hZZ;
    tick();
    rdn = 1'b0;
    tick();
    @(negedge clk);
    oe_early = oe;
    repeat (4) tick();
    rdn = 1'b1;
    repeat (3) tick();
    csn = 2'b11;
    tick();
    tick();
    data      = oe_data;
    oe_cycles = oe_cnt - oe0;
  endtask

  task automatic test_reset();
    bus_idle();
    rstn = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    checks++;
    if (oe !== 1'b0 || badd_o !== 8'h00) begin
      errors++;
      $display("FAIL reset_bus oe=%b data=%h expected oe=0 data=00", oe, badd_o);
    end
    checks++;
    if (wr_stb !== 1'b0 || wr_add !== 8'h00 || wr_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_wr stb=%b add=%h data=%h expected 0/00/00", wr_stb, wr_add, wr_data);
    end
    checks++;
    if (prot_err !== 1'b0 || irq !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags prot=%b irq=%b expected 0/0", prot_err, irq);
    end
    tick();
    rstn = 1'b1;
    repeat (3) tick();
    checks++;
    if (oe !== 1'b0 || prot_err !== 1'b0 || wr_stb !== 1'b0) begin
      errors++;
      $display("FAIL post_reset oe=%b prot=%b stb=%b expected 0/0/0", oe, prot_err, wr_stb);
    end
  endtask

  task automatic test_write_read();
    int s0;
    logic [7:0] d;
    int n;
    logic e;
    s0 = stb_cnt;
    do_write(8'h12, 8'hA5, 0, 1'b0);
    checks++;
    if (stb_cnt - s0 !== 1) begin
      errors++;
      $display("FAIL wr_stb_count got %0d expected 1", stb_cnt - s0);
    end
    checks++;
    if (wr_add !== 8'h12 || wr_data !== 8'hA5) begin
      errors++;
      $display("FAIL wr_regs add=%h data=%h expected 12/a5", wr_add, wr_data);
    end
    do_read(8'h12, d, n, e);
    checks++;
    if (d !== 8'hA5) begin
      errors++;
      $display("FAIL read_12 got %h expected a5", d);
    end
    checks++;
    if (n !== 5 || e !== 1'b0) begin
      errors++;
      $display("FAIL read_oe_window cycles=%0d early=%b expected 5/0", n, e);
    end
  endtask

  task automatic test_id_and_range();
    int s0;
    logic [7:0] d;
    int n;
    logic e;
    do_read(8'h00, d, n, e);
    checks++;
    if (d !== 8'h56) begin
      errors++;
      $display("FAIL read_id got %h expected 56", d);
    end
    s0 = stb_cnt;
    do_write(8'h00, 8'hFF, 0, 1'b0);
    checks++;
    if (stb_cnt !== s0) begin
      errors++;
      $display("FAIL wr_id_ignored strobes=%0d expected 0", stb_cnt - s0);
    end
    do_read(8'h00, d, n, e);
    checks++;
    if (d !== 8'h56) begin
      errors++;
      $display("FAIL reread_id got %h expected 56", d);
    end
    s0 = stb_cnt;
    do_write(8'h80, 8'h77, 0, 1'b0);
    checks++;
    if (stb_cnt !== s0) begin
      errors++;
      $display("FAIL wr_80_ignored strobes=%0d expected 0", stb_cnt - s0);
    end
    do_read(8'h80, d, n, e);
    checks++;
    if (d !== 8'h00 || n !== 5) begin
      errors++;
      $display("FAIL read_80 data=%h oe_cycles=%0d expected 00/5", d, n);
    end
  endtask

  task automatic test_both_strobes();
    int s0;
    int p0;
    int o0;
    s0 = stb_cnt;
    p0 = prot_cnt;
    o0 = oe_cnt;
    bus_addr(8'h20);
    badd_i = 8'h99;
    tick();
    wrn = 1'b0;
    rdn = 1'b0;
    repeat (4) tick();
    wrn = 1'b1;
    rdn = 1'b1;
    repeat (3) tick();
    csn = 2'b11;
    tick();
    tick();
    checks++;
    if (prot_cnt - p0 !== 1) begin
      errors++;
      $display("FAIL both_strobes_prot pulses=%0d expected 1", prot_cnt - p0);
    end
    checks++;
    if (stb_cnt !== s0 || oe_cnt !== o0) begin
      errors++;
      $display("FAIL both_strobes_access strobes=%0d oe=%0d expected 0/0", stb_cnt - s0, oe_cnt - o0);
    end
  endtask

  task automatic test_cs_abort();
    int s0;
    int p0;
    logic [7:0] d;
    int n;
    logic e;
    s0 = stb_cnt;
    p0 = prot_cnt;
    do_write(8'h05, 8'h33, 0, 1'b1);
    checks++;
    if (prot_cnt - p0 !== 1 || stb_cnt !== s0) begin
      errors++;
      $display("FAIL cs_abort prot=%0d strobes=%0d expected 1/0", prot_cnt - p0, stb_cnt - s0);
    end
    do_read(8'h05, d, n, e);
    checks++;
    if (d !== 8'h00) begin
      errors++;
      $display("FAIL read_05 got %h expected 00", d);
    end
  endtask

  task automatic test_timeout();
    int s0;
    int p0;
    s0 = stb_cnt;
    do_write(8'h08, 8'h45, 55, 1'b0);
    checks++;
    if (stb_cnt - s0 !== 1 || wr_add !== 8'h08 || wr_data !== 8'h45) begin
      errors++;
      $display("FAIL slow_write strobes=%0d add=%h data=%h expected 1/08/45", stb_cnt - s0, wr_add, wr_data);
    end
    s0 = stb_cnt;
    p0 = prot_cnt;
    do_write(8'h07, 8'h44, 70, 1'b0);
    checks++;
    if (stb_cnt !== s0 || prot_cnt !== p0) begin
      errors++;
      $display("FAIL timeout strobes=%0d prot=%0d expected 0/0", stb_cnt - s0, prot_cnt - p0);
    end
  endtask

  task automatic test_ale_in_read();
    int p0;
    logic [7:0] d;
    int n;
    logic e;
    p0 = prot_cnt;
    bus_addr(8'h12);
    tick();
    rdn = 1'b0;
    repeat (3) tick();
    rdn    = 1'b1;
    ale    = 1'b1;
    badd_i = 8'h12;
    tick();
    tick();
    ale = 1'b0;
    tick();
    csn = 2'b11;
    repeat (3) tick();
    @(negedge clk);
    checks++;
    if (prot_cnt - p0 !== 1 || oe !== 1'b0) begin
      errors++;
      $display("FAIL ale_in_read prot=%0d oe=%b expected 1/0", prot_cnt - p0, oe);
    end
    do_read(8'h12, d, n, e);
    checks++;
    if (d !== 8'hA5) begin
      errors++;
      $display("FAIL read_after_ale got %h expected a5", d);
    end
  endtask

  task automatic test_reset_in_read();
    logic [7:0] d;
    int n;
    logic e;
    bus_addr(8'h12);
    tick();
    rdn = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    checks++;
    if (oe !== 1'b1 || badd_o !== 8'hA5) begin
      errors++;
      $display("FAIL pre_reset_read oe=%b data=%h expected 1/a5", oe, badd_o);
    end
    tick();
    rstn = 1'b0;
    tick();
    checks++;
    if (oe !== 1'b0) begin
      errors++;
      $display("FAIL reset_drops_oe oe=%b expected 0", oe);
    end
    bus_idle();
    tick();
    rstn = 1'b1;
    tick();
    do_read(8'h12, d, n, e);
    checks++;
    if (d !== 8'h00 || n !== 5) begin
      errors++;
      $display("FAIL read_12_after_reset data=%h oe_cycles=%0d expected 00/5", d, n);
    end
  endtask

  task automatic test_irq();
    logic [7:0] d;
    int n;
    logic e;
    do_write(8'h3F, 8'h01, 0, 1'b0);
`ifdef F56_RESP_IRQ_EN
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL irq_set got %b expected 1", irq);
    end
    do_read(8'h01, d, n, e);
    checks++;
    if (d !== 8'h01 || irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_ack data=%h irq=%b expected 01/0", d, irq);
    end
    do_read(8'h01, d, n, e);
    checks++;
    if (d !== 8'h00) begin
      errors++;
      $display("FAIL irq_reg_cleared got %h expected 00", d);
    end
    do_write(8'h3F, 8'h00, 0, 1'b0);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_zero_write got %b expected 0", irq);
    end
`else
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_disabled got %b expected 0", irq);
    end
    do_read(8'h3F, d, n, e);
    checks++;
    if (d !== 8'h01) begin
      errors++;
      $display("FAIL read_3f got %h expected 01", d);
    end
    do_read(8'h01, d, n, e);
    checks++;
    if (d !== 8'h00 || irq !== 1'b0) begin
      errors++;
      $display("FAIL read_01_plain data=%h irq=%b expected 00/0", d, irq);
    end
`endif
  endtask

  initial begin
    rstn = 1'b0;
    bus_idle();
    test_reset();
    test_write_read();
    test_id_and_range();
    test_both_strobes();
    test_cs_abort();
    test_timeout();
    test_ale_in_read();
    test_reset_in_read();
    test_irq();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
